micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Parametrised micro-program sequencer for the micro-programmed CU. Holds the
//  micro-address register (uaddr) feeding Umem, computes the next address from
//  the current microinstruction's sequencing field, and dispatches opcodes via
//  a runtime-writable entry table. Adds halt state, illegal-opcode trap and op handshake.
// PARAMETERS
//  OP_W        6          opcode width (5-bit op + immediate flag); table depth = 2**OP_W
//  UADDR_W     16         micro-address width
//  ENTRY_BASE  16'h0400   reset table value base: entry[i] = ENTRY_BASE | (i << ENTRY_SHIFT)
//  ENTRY_SHIFT 4          left shift of opcode in reset table value
//  HALT_OP     6'b111110  opcode that enters HALT
//  FETCH_ADDR  16'h0000   micro-address of the fetch routine
//  TRAP_ADDR   16'hFFF0   micro-address taken on invalid table entry
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  next_sel   in   2        00 INC, 01 JUMP(cond), 10 DISPATCH, 11 FETCH
//  jump_addr  in   UADDR_W  target for JUMP
//  cond       in   1        JUMP taken when 1
//  opcode     in   OP_W     opcode from IR
//  op_valid   in   1        opcode present
//  op_ready   out  1        sequencer accepts opcode this cycle (combinational)
//  resume     in   1        leave HALT
//  tbl_we     in   1        table write strobe
//  tbl_waddr  in   OP_W     table index
//  tbl_wdata  in   UADDR_W  entry address
//  tbl_wvalid in   1        valid bit written with entry
//  uaddr      out  UADDR_W  current micro-address (registered)
//  halted     out  1        1 while in HALT
//  illegal_op out  1        one-cycle pulse on dispatch to invalid entry
// BEHAVIOUR
//  Reset (async, any time, highest priority): uaddr=FETCH_ADDR, state=RUN, halted=0,
//   illegal_op=0; every table entry = ENTRY_BASE|(i<<ENTRY_SHIFT) truncated to UADDR_W, valid=1.
//  States: RUN, WAIT_OP, HALT. All uaddr updates are registered: 1-cycle latency.
//  RUN, per cycle by next_sel:
//   INC: uaddr <= uaddr+1, wraps modulo 2**UADDR_W (all ones -> 0).
//   JUMP: cond ? jump_addr : uaddr+1.
//   FETCH: uaddr <= FETCH_ADDR.
//   DISPATCH: op_ready=1. op_valid=1 -> dispatch (below); op_valid=0 -> uaddr held, go WAIT_OP.
//  WAIT_OP: op_ready=1, uaddr held, next_sel ignored; on op_valid -> dispatch, go RUN.
//  HALT: op_ready=0, uaddr held, halted=1, next_sel/op_valid ignored; resume=1 ->
//   uaddr <= FETCH_ADDR, halted <= 0, go RUN.
//  op_ready=0 in RUN unless next_sel==DISPATCH. Transfer = op_valid & op_ready.
//  Dispatch priority: opcode==HALT_OP -> uaddr<=FETCH_ADDR, halted<=1, go HALT (regardless
//   of table); else entry invalid -> uaddr<=TRAP_ADDR, illegal_op=1 for one cycle, RUN;
//   else uaddr <= entry, RUN.
//  Table write: synchronous on tbl_we, in any state incl. HALT. Same-cycle write and
//   dispatch of same index: dispatch uses OLD value (read-before-write).
//   tbl_wvalid=0 invalidates entry. HALT_OP entry is writable but never consulted.
//  resume outside HALT: ignored. resume with rst: rst wins.
//  No X on outputs after reset; opcode ignored unless transfer occurs.
// TESTING
//  1 Reset then DISPATCH opcode 6'b000110, op_valid=1 -> next cycle uaddr=16'h0460, op_ready was 1.
//  2 uaddr=16'hFFFF, INC -> 16'h0000; JUMP cond=0 from 16'h0010 -> 16'h0011; cond=1 jump_addr=16'h0200 -> 16'h0200.
//  3 DISPATCH with op_valid=0 for 3 cycles -> uaddr held, op_ready=1 each cycle; then
//    op_valid=1 opcode 6'b000010 -> uaddr=16'h0420, state RUN.
//  4 Write idx 6'b001000 data 16'h0ABC valid=1 while dispatching 6'b001000 same cycle ->
//    uaddr=16'h0480; redispatch -> 16'h0ABC. Write valid=0, dispatch -> uaddr=16'hFFF0, illegal_op 1 cycle.
//  5 Dispatch 6'b111110 -> halted=1, uaddr=16'h0000, op_ready=0; INC/op_valid ignored 5
//    cycles; resume=1 -> halted=0, uaddr=16'h0000, RUN.
//  6 Assert rst mid-WAIT_OP and mid-HALT after table writes -> outputs reset immediately
//    (async), table restored to reset map, op_ready=0 with next_sel=INC.

Source files
------------

// File: rtl/micro_sequencer.sv
// Micro-program sequencer: owns the micro-address register, computes the next
// address from the sequencing field, and dispatches opcodes through a writable entry table.
module micro_sequencer #(
    parameter int                 OP_W        = 6,
    parameter int                 UADDR_W     = 16,
    parameter logic [UADDR_W-1:0] ENTRY_BASE  = 16'h0400,
    parameter int                 ENTRY_SHIFT = 4,
    parameter logic [OP_W-1:0]    HALT_OP     = 6'b111110,
    parameter logic [UADDR_W-1:0] FETCH_ADDR  = 16'h0000,
    parameter logic [UADDR_W-1:0] TRAP_ADDR   = 16'hFFF0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         next_sel,
    input  logic [UADDR_W-1:0] jump_addr,
    input  logic               cond,
    input  logic [OP_W-1:0]    opcode,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic               resume,
    input  logic               tbl_we,
    input  logic [OP_W-1:0]    tbl_waddr,
    input  logic [UADDR_W-1:0] tbl_wdata,
    input  logic               tbl_wvalid,
    output logic [UADDR_W-1:0] uaddr,
    output logic               halted,
    output logic               illegal_op
);

    localparam int DEPTH = 1 << OP_W;

    localparam logic [1:0] SEL_INC   = 2'b00;
    localparam logic [1:0] SEL_JUMP  = 2'b01;
    localparam logic [1:0] SEL_DISP  = 2'b10;
    localparam logic [1:0] SEL_FETCH = 2'b11;

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    logic [1:0]         r_state;
    logic [UADDR_W-1:0] r_uaddr;
    logic               r_halted;
    logic               r_illegal;
    logic [UADDR_W-1:0] r_tbl [0:DEPTH-1];
    logic [DEPTH-1:0]   r_tbl_v;

    logic [1:0]         w_state_nxt;
    logic [UADDR_W-1:0] w_uaddr_nxt;
    logic               w_halted_nxt;
    logic               w_illegal_nxt;
    logic               w_op_ready;
    logic               w_xfer;
    logic [UADDR_W-1:0] w_uaddr_inc;
    logic [UADDR_W-1:0] w_entry;
    logic               w_entry_v;

    function automatic logic [UADDR_W-1:0] f_reset_entry(input int unsigned idx);
        f_reset_entry = ENTRY_BASE | UADDR_W'(idx << ENTRY_SHIFT);
    endfunction

    assign w_uaddr_inc = r_uaddr + {{(UADDR_W-1){1'b0}}, 1'b1};
    // Table read is taken from the registered array, so a same-cycle write is not yet visible
    assign w_entry     = r_tbl[opcode];
    assign w_entry_v   = r_tbl_v[opcode];
    assign w_xfer      = op_valid & w_op_ready;

    // Opcode acceptance depends only on the current state and sequencing field
    always_comb begin
        w_op_ready = 1'b0;
        case (r_state)
            ST_RUN:  w_op_ready = (next_sel == SEL_DISP);
            ST_WAIT: w_op_ready = 1'b1;
            ST_HALT: w_op_ready = 1'b0;
            default: w_op_ready = 1'b0;
        endcase
    end

    // Next-address, next-state and status computation
    always_comb begin
        w_state_nxt   = r_state;
        w_uaddr_nxt   = r_uaddr;
        w_halted_nxt  = r_halted;
        w_illegal_nxt = 1'b0;
        if (w_xfer) begin
            if (opcode == HALT_OP) begin
                w_state_nxt  = ST_HALT;
                w_uaddr_nxt  = FETCH_ADDR;
                w_halted_nxt = 1'b1;
            end else if (!w_entry_v) begin
                w_state_nxt   = ST_RUN;
                w_uaddr_nxt   = TRAP_ADDR;
                w_illegal_nxt = 1'b1;
            end else begin
                w_state_nxt = ST_RUN;
                w_uaddr_nxt = w_entry;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    case (next_sel)
                        SEL_INC:   w_uaddr_nxt = w_uaddr_inc;
                        SEL_JUMP:  w_uaddr_nxt = cond ? jump_addr : w_uaddr_inc;
                        SEL_DISP:  w_state_nxt = ST_WAIT;
                        SEL_FETCH: w_uaddr_nxt = FETCH_ADDR;
                        default:   w_uaddr_nxt = r_uaddr;
                    endcase
                end
                ST_WAIT: w_state_nxt = ST_WAIT;
                ST_HALT: begin
                    if (resume) begin
                        w_state_nxt  = ST_RUN;
                        w_uaddr_nxt  = FETCH_ADDR;
                        w_halted_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_HALT;
                    end
                end
                default: begin
                    w_state_nxt  = ST_RUN;
                    w_uaddr_nxt  = FETCH_ADDR;
                    w_halted_nxt = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_uaddr   <= FETCH_ADDR;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_uaddr   <= w_uaddr_nxt;
            r_halted  <= w_halted_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    // Dispatch table; reset restores the computed default map with every entry valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl[i] <= f_reset_entry(i);
            end
            r_tbl_v <= {DEPTH{1'b1}};
        end else if (tbl_we) begin
            r_tbl[tbl_waddr]   <= tbl_wdata;
            r_tbl_v[tbl_waddr] <= tbl_wvalid;
        end
    end

    assign op_ready   = w_op_ready;
    assign uaddr      = r_uaddr;
    assign halted     = r_halted;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed scoreboard bench for micro_sequencer: expected post-edge outputs are
// queued when a cycle is driven and compared once the DUT has registered them.
module tb_micro_sequencer;

    logic        clk;
    logic        rst;
    logic [1:0]  next_sel;
    logic [15:0] jump_addr;
    logic        cond;
    logic [5:0]  opcode;
    logic        op_valid;
    logic        op_ready;
    logic        resume;
    logic        tbl_we;
    logic [5:0]  tbl_waddr;
    logic [15:0] tbl_wdata;
    logic        tbl_wvalid;
    logic [15:0] uaddr;
    logic        halted;
    logic        illegal_op;

    typedef struct {
        logic [15:0] ua;
        logic        h;
        logic        il;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    micro_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .next_sel   (next_sel),
        .jump_addr  (jump_addr),
        .cond       (cond),
        .opcode     (opcode),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .resume     (resume),
        .tbl_we     (tbl_we),
        .tbl_waddr  (tbl_waddr),
        .tbl_wdata  (tbl_wdata),
        .tbl_wvalid (tbl_wvalid),
        .uaddr      (uaddr),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ns, input logic [15:0] ja, input logic c,
                         input logic [5:0] op, input logic ov, input logic rs);
        next_sel  = ns;
        jump_addr = ja;
        cond      = c;
        opcode    = op;
        op_valid  = ov;
        resume    = rs;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic v);
        tbl_we     = 1'b1;
        tbl_waddr  = a;
        tbl_wdata  = d;
        tbl_wvalid = v;
    endtask

    task automatic tick(input logic [15:0] ua, input logic h, input logic il, input string tag);
        exp_t e;
        e.ua = ua; e.h = h; e.il = il; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        e = exp_q.pop_front();
        check_eq({e.tag, "_uaddr"}, 32'(uaddr), 32'(e.ua));
        check_eq({e.tag, "_halted"}, 32'(halted), 32'(e.h));
        check_eq({e.tag, "_illegal"}, 32'(illegal_op), 32'(e.il));
    endtask

    localparam logic [1:0] INC  = 2'b00;
    localparam logic [1:0] JMP  = 2'b01;
    localparam logic [1:0] DISP = 2'b10;
    localparam logic [1:0] FET  = 2'b11;

    initial begin
        rst = 1'b1;
        drive(INC, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b0);
        tbl_we = 1'b0; tbl_waddr = 6'h00; tbl_wdata = 16'h0000; tbl_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_uaddr", 32'(uaddr), 32'h0000);
        check_eq("rst_halted", 32'(halted), 32'h0);
        check_eq("rst_illegal", 32'(illegal_op), 32'h0);
        check_eq("rst_ready", 32'(op_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Default-map dispatch
        drive(DISP, 16'h0000, 1'b0, 6'b000110, 1'b1, 1'b0);
        #1 check_eq("t1_ready", 32'(op_ready), 32'h1);
        tick(16'h0460, 1'b0, 1'b0, "t1");

        // Increment wrap and conditional jump
        drive(JMP, 16'hFFFF, 1'b1, 6'h00, 1'b0, 1'b0); tick(16'hFFFF, 1'b0, 1'b0, "t2_jmp_ffff");
        drive(INC, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b0); tick(16'h0000, 1'b0, 1'b0, "t2_wrap");
        drive(JMP, 16'h0010, 1'b1, 6'h00, 1'b0, 1'b0); tick(16'h0010, 1'b0, 1'b0, "t2_jmp_10");
        drive(JMP, 16'h0200, 1'b0, 6'h00, 1'b0, 1'b0); tick(16'h0011, 1'b0, 1'b0, "t2_nojmp");
        drive(JMP, 16'h0200, 1'b1, 6'h00, 1'b0, 1'b0); tick(16'h0200, 1'b0, 1'b0, "t2_jmp_200");
        drive(FET, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b0); tick(16'h0000, 1'b0, 1'b0, "t2_fetch");

        // Dispatch stalls in WAIT_OP until an opcode arrives
        drive(JMP, 16'h0123, 1'b1, 6'h00, 1'b0, 1'b0); tick(16'h0123, 1'b0, 1'b0, "t3_pre");
        for (int i = 0; i < 3; i++) begin
            drive((i == 0) ? DISP : INC, 16'h0000, 1'b0, 6'h11, 1'b0, 1'b0);
            #1 check_eq("t3_wait_ready", 32'(op_ready), 32'h1);
            tick(16'h0123, 1'b0, 1'b0, "t3_hold");
        end
        drive(INC, 16'h0000, 1'b0, 6'b000010, 1'b1, 1'b0);
        #1 check_eq("t3_ready", 32'(op_ready), 32'h1);
        tick(16'h0420, 1'b0, 1'b0, "t3_disp");
        drive(INC, 16'h0000, 1'b0, 6'h05, 1'b1, 1'b0);
        #1 check_eq("t3_run_ready", 32'(op_ready), 32'h0);
        tick(16'h0421, 1'b0, 1'b0, "t3_run_inc");

        // Read-before-write on the table, then invalidate and trap
        wr(6'b001000, 16'h0ABC, 1'b1);
        drive(DISP, 16'h0000, 1'b0, 6'b001000, 1'b1, 1'b0); tick(16'h0480, 1'b0, 1'b0, "t4_old");
        drive(DISP, 16'h0000, 1'b0, 6'b001000, 1'b1, 1'b0); tick(16'h0ABC, 1'b0, 1'b0, "t4_new");
        wr(6'b001000, 16'h0000, 1'b0);
        drive(INC, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b0);       tick(16'h0ABD, 1'b0, 1'b0, "t4_inv_wr");
        drive(DISP, 16'h0000, 1'b0, 6'b001000, 1'b1, 1'b0); tick(16'hFFF0, 1'b0, 1'b1, "t4_trap");
        drive(INC, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b0);       tick(16'hFFF1, 1'b0, 1'b0, "t4_pulse_end");

        // HALT entry, ignored inputs while halted, resume
        drive(DISP, 16'h0000, 1'b0, 6'b111110, 1'b1, 1'b0); tick(16'h0000, 1'b1, 1'b0, "t5_halt");
        for (int i = 0; i < 5; i++) begin
            drive((i % 2 == 0) ? INC : DISP, 16'h0000, 1'b0, 6'h06, 1'b1, 1'b0);
            #1 check_eq("t5_ready", 32'(op_ready), 32'h0);
            tick(16'h0000, 1'b1, 1'b0, "t5_hold");
        end
        drive(INC, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b1); tick(16'h0000, 1'b0, 1'b0, "t5_resume");
        drive(INC, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b0); tick(16'h0001, 1'b0, 1'b0, "t5_run");
        drive(INC, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b1); tick(16'h0002, 1'b0, 1'b0, "t5_stray_resume");

        // Async reset in WAIT_OP restores outputs and table
        wr(6'h06, 16'h1234, 1'b1);
        drive(JMP, 16'h0555, 1'b1, 6'h00, 1'b0, 1'b0);  tick(16'h0555, 1'b0, 1'b0, "t6_pre");
        drive(DISP, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b0); tick(16'h0555, 1'b0, 1'b0, "t6_wait");
        drive(INC, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_uaddr", 32'(uaddr), 32'h0000);
        check_eq("t6_rst_halted", 32'(halted), 32'h0);
        check_eq("t6_rst_ready", 32'(op_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(DISP, 16'h0000, 1'b0, 6'h06, 1'b1, 1'b0);
        #1 check_eq("t6_ready", 32'(op_ready), 32'h1);
        tick(16'h0460, 1'b0, 1'b0, "t6_restored");

        // Async reset in HALT after invalidating an entry
        wr(6'h09, 16'h0777, 1'b0);
        drive(INC, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b0);      tick(16'h0461, 1'b0, 1'b0, "t6_wr9");
        drive(DISP, 16'h0000, 1'b0, 6'b111110, 1'b1, 1'b0); tick(16'h0000, 1'b1, 1'b0, "t6_halt");
        drive(INC, 16'h0000, 1'b0, 6'h00, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_hrst_halted", 32'(halted), 32'h0);
        check_eq("t6_hrst_illegal", 32'(illegal_op), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(DISP, 16'h0000, 1'b0, 6'h09, 1'b1, 1'b0); tick(16'h0490, 1'b0, 1'b0, "t6_valid9");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
